comparador_scanner: RTL and testbench
=====================================

# comparador_scanner

Self-checking sweep engine that drives the operand side of the 2-bit magnitude comparator and consumes its three result flags. It also compares those flags against the expected result. On `start` it applies all 16 {A,B} operand pairs in ascending order and waits a programmable settle time per pair. It then samples A<B / A=B / A>B, counts mismatches, and records the first failing pair. It sits beside the comparator as its initiator, for board-level self-test and simulation sign-off.

## Interface
- `SETTLE_CYCLES`, default 1: extra cycles each pair is held before its flags are sampled; legal range 0..15.
- `clk`  in  1  single system clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  scan request; level-sampled in IDLE only.
- `a_out`  out  2  operand A to comparator (bit1 = A1, bit0 = A0); registered.
- `b_out`  out  2  operand B to comparator (bit1 = B1, bit0 = B0); registered.
- `lt_in`  in  1  comparator A<B flag.
- `eq_in`  in  1  comparator A=B flag.
- `gt_in`  in  1  comparator A>B flag.
- `busy`  out  1  high while a scan is in progress.
- `done`  out  1  one-cycle pulse when a scan completes.
- `err_cnt`  out  5  number of failing pairs in the last scan, 0..16.
- `first_err_valid`  out  1  at least one pair failed in the last scan.
- `first_err_pair`  out  4  {A,B} of the lowest-index failing pair.
- `pass`  out  1  last completed scan had `err_cnt` = 0.

## Operation
- The states are IDLE, RUN and DONE.
- Reset (any time, async) sets every output to 0, the FSM to IDLE, and the pair index and settle counter to 0.
- IDLE with `start`=1 at a clock edge:
  - go to RUN; `busy`<=1;
  - clear `err_cnt`, `first_err_valid`, `first_err_pair` and `pass`;
  - pair index idx<=0; `a_out`<=idx[3:2], `b_out`<=idx[1:0].
- RUN, per pair:
  - the settle counter counts SETTLE_CYCLES cycles;
  - on the following edge (the sample edge), compute expected lt=(A<B), eq=(A==B), gt=(A>B), unsigned;
  - the pair fails if any of the three input flags differs from expected, including all-zero or multi-hot flags;
  - on failure: `err_cnt`+1; if `first_err_valid`=0, latch the pair into `first_err_pair` and set `first_err_valid`.
- Sample edge with idx<15: idx<=idx+1 and drive the new pair on that same edge.
- Sample edge with idx=15: go to DONE; `a_out`/`b_out`<=0; `busy`<=0; `done`<=1; `pass`<=(final err_cnt==0).
- DONE lasts one cycle: `done`<=0, then IDLE.
- `start` is ignored in RUN and DONE. `start` held high in IDLE starts a new scan on every return to IDLE.
- Results (`err_cnt`, `first_err_*`, `pass`) hold until the next accepted `start` or reset.
- Width: `err_cnt` is 5 bits so the value 16 is representable and never wraps. idx is 4 bits and never wraps, because completion occurs at idx=15.
- Reset mid-scan aborts with no `done` pulse and all results cleared.

## Timing
- Let edge k be the edge at which `start` is accepted.
- Pair i is driven from edge k+i·(S+1) and sampled at edge k+(i+1)·(S+1), where S=SETTLE_CYCLES.
- With S=0, the flags are sampled one full cycle after the operands change. The comparator path must meet single-cycle timing.
- The last sample occurs at edge k+16·(S+1). `done` is high for exactly the cycle after that edge, and `busy` falls on that same edge.
- `busy` is high for 16·(S+1) cycles.
- The earliest next accepted `start` is edge k+16·(S+1)+2, after the DONE cycle.
- The input flags are only sampled at sample edges; glitches between sample edges are ignored.

## Test plan
- Ideal behavioural comparator, S=1, `start` pulse:
  - the bench sees 16 pairs 0000..1111, each held 2 cycles;
  - `done` 32 cycles after the start edge;
  - `err_cnt`=0, `pass`=1, `first_err_valid`=0.
- Model with `eq_in` stuck at 0, S=1: `err_cnt`=4, `first_err_pair`=0000, `first_err_valid`=1, `pass`=0.
- Model with lt/gt swapped, S=0:
  - `done` 16 cycles after start;
  - `err_cnt`=12, `first_err_pair`=0001.
- Model with all flags stuck at 1, S=3: `err_cnt`=16 (no wrap), `first_err_pair`=0000, `done` after 64 cycles.
- `start` re-pulsed at cycles 5 and 20 of a running S=1 scan: the scan is unaffected and exactly one `done` pulse occurs at cycle 32.
- Assert `rst` asynchronously while pair 7 is driven:
  - all outputs are 0 immediately, with no `done`;
  - a following `start` produces a full, clean scan.

Source files
------------

// File: rtl/comparador_scanner_if.sv
// Operand/flag/result bundle between the sweep engine and the comparator side.
interface comparador_scanner_if;
  logic       start;
  logic [1:0] a_out;
  logic [1:0] b_out;
  logic       lt_in;
  logic       eq_in;
  logic       gt_in;
  logic       busy;
  logic       done;
  logic [4:0] err_cnt;
  logic       first_err_valid;
  logic [3:0] first_err_pair;
  logic       pass;

  modport master (
    input  start, lt_in, eq_in, gt_in,
    output a_out, b_out, busy, done, err_cnt, first_err_valid, first_err_pair, pass
  );

  modport slave (
    output start, lt_in, eq_in, gt_in,
    input  a_out, b_out, busy, done, err_cnt, first_err_valid, first_err_pair, pass
  );
endinterface

// File: rtl/comparador_scanner.sv
// Sweeps all 16 {A,B} pairs into a 2-bit magnitude comparator and checks its
// lt/eq/gt flags against the ideal result, counting and locating failures.
module comparador_scanner #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  comparador_scanner_if.master bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

  logic [1:0] state;
  logic [3:0] idx;
  logic [3:0] idx_next;
  logic [3:0] settle_cnt;
  logic       sample;
  logic       fail;
  logic [4:0] err_next;

  function automatic logic [2:0] expected_flags(input logic [1:0] a, input logic [1:0] b);
    return {a < b, a == b, a > b};
  endfunction

  // Multi-hot or all-zero flag sets never equal the one-hot expectation, so they fail too.
  assign sample   = (state == RUN) && (settle_cnt == SETTLE);
  assign fail     = {bus.lt_in, bus.eq_in, bus.gt_in} != expected_flags(bus.a_out, bus.b_out);
  assign err_next = bus.err_cnt + {4'd0, fail};
  assign idx_next = idx + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      idx                 <= 4'd0;
      settle_cnt          <= 4'd0;
      bus.a_out           <= 2'd0;
      bus.b_out           <= 2'd0;
      bus.busy            <= 1'b0;
      bus.done            <= 1'b0;
      bus.err_cnt         <= 5'd0;
      bus.first_err_valid <= 1'b0;
      bus.first_err_pair  <= 4'd0;
      bus.pass            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state               <= RUN;
            bus.busy            <= 1'b1;
            bus.err_cnt         <= 5'd0;
            bus.first_err_valid <= 1'b0;
            bus.first_err_pair  <= 4'd0;
            bus.pass            <= 1'b0;
            idx                 <= 4'd0;
            settle_cnt          <= 4'd0;
            bus.a_out           <= 2'd0;
            bus.b_out           <= 2'd0;
          end
        end

        RUN: begin
          if (!sample) begin
            settle_cnt <= settle_cnt + 4'd1;
          end else begin
            settle_cnt  <= 4'd0;
            bus.err_cnt <= err_next;
            if (fail && !bus.first_err_valid) begin
              bus.first_err_valid <= 1'b1;
              bus.first_err_pair  <= idx;
            end
            // Completion at idx=15 means the 4-bit index never wraps.
            if (idx == 4'd15) begin
              state     <= DONE;
              bus.a_out <= 2'd0;
              bus.b_out <= 2'd0;
              bus.busy  <= 1'b0;
              bus.done  <= 1'b1;
              bus.pass  <= (err_next == 5'd0);
            end else begin
              idx       <= idx_next;
              bus.a_out <= idx_next[3:2];
              bus.b_out <= idx_next[1:0];
            end
          end
        end

        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comparador_scanner.sv
// Directed bench: three scanners (S=1, S=0, S=3) each paired with a configurable
// comparator model; scans are table-driven, corner cases are hand-written.
module tb_comparador_scanner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [4:0] err_cnt;
    logic       fev;
    logic [3:0] fep;
    logic       pass;
    logic [1:0] a;
    logic [1:0] b;
  } obs_t;

  typedef struct {
    int         dut;
    logic [1:0] mode;
    int         lat;
    int         err;
    logic       fev;
    logic [3:0] fep;
    logic       pass;
  } vec_t;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   s_of [3] = '{1, 0, 3};
  logic       start_v [3];
  logic [1:0] mode_v  [3];
  obs_t       obs     [3];
  vec_t       vecs    [6];

  // mode 0 ideal, 1 eq stuck at 0, 2 lt/gt swapped, 3 all flags stuck at 1
  function automatic logic [2:0] model(input logic [1:0] m, input logic [1:0] a, input logic [1:0] b);
    int  ai = int'(a);
    int  bi = int'(b);
    logic lt = (ai < bi);
    logic eq = (ai == bi);
    logic gt = (ai > bi);
    case (m)
      2'd0:    return {lt, eq, gt};
      2'd1:    return {lt, 1'b0, gt};
      2'd2:    return {gt, eq, lt};
      default: return 3'b111;
    endcase
  endfunction

  comparador_scanner_if if0 ();
  comparador_scanner_if if1 ();
  comparador_scanner_if if2 ();

  comparador_scanner #(.SETTLE_CYCLES(1)) dut_s1 (.clk(clk), .rst(rst), .bus(if0));
  comparador_scanner #(.SETTLE_CYCLES(0)) dut_s0 (.clk(clk), .rst(rst), .bus(if1));
  comparador_scanner #(.SETTLE_CYCLES(3)) dut_s3 (.clk(clk), .rst(rst), .bus(if2));

  assign if0.start = start_v[0];
  assign if1.start = start_v[1];
  assign if2.start = start_v[2];
  assign {if0.lt_in, if0.eq_in, if0.gt_in} = model(mode_v[0], if0.a_out, if0.b_out);
  assign {if1.lt_in, if1.eq_in, if1.gt_in} = model(mode_v[1], if1.a_out, if1.b_out);
  assign {if2.lt_in, if2.eq_in, if2.gt_in} = model(mode_v[2], if2.a_out, if2.b_out);
  assign obs[0] = {if0.busy, if0.done, if0.err_cnt, if0.first_err_valid, if0.first_err_pair, if0.pass, if0.a_out, if0.b_out};
  assign obs[1] = {if1.busy, if1.done, if1.err_cnt, if1.first_err_valid, if1.first_err_pair, if1.pass, if1.a_out, if1.b_out};
  assign obs[2] = {if2.busy, if2.done, if2.err_cnt, if2.first_err_valid, if2.first_err_pair, if2.pass, if2.a_out, if2.b_out};

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pulse start on DUT d; optionally re-pulse start at cycles p1/p2 of the run.
  // Returns done latency in cycles after the start edge and the number of done pulses.
  task automatic run_scan(input int d, input int p1, input int p2, output int lat, output int ndone);
    int s     = s_of[d];
    int total = 16 * (s + 1);
    int pair;
    lat   = -1;
    ndone = 0;
    @(negedge clk);
    start_v[d] = 1'b1;
    @(posedge clk);
    #1;
    for (int j = 0; j <= total + 4; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
      end
      start_v[d] = (j == p1 || j == p2);
      if (obs[d].done) begin
        ndone++;
        if (lat < 0) lat = j;
      end
      if (j < total) begin
        pair = j / (s + 1);
        check($sformatf("seq d%0d j%0d busy/a/b", d, j),
              int'({obs[d].busy, obs[d].a, obs[d].b}), 16 + pair);
      end else if (j == total) begin
        check($sformatf("end d%0d busy/a/b", d), int'({obs[d].busy, obs[d].a, obs[d].b}), 0);
      end
    end
    start_v[d] = 1'b0;
  endtask

  task automatic check_results(input string tag, input int d, input int err, input logic fev,
                               input logic [3:0] fep, input logic pass);
    check({tag, " err_cnt"}, int'(obs[d].err_cnt), err);
    check({tag, " first_err_valid"}, int'(obs[d].fev), int'(fev));
    check({tag, " first_err_pair"}, int'(obs[d].fep), int'(fep));
    check({tag, " pass"}, int'(obs[d].pass), int'(pass));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nd;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      mode_v[i]  = 2'd0;
    end
    vecs[0] = '{0, 2'd0, 32, 0,  1'b0, 4'd0, 1'b1};
    vecs[1] = '{0, 2'd1, 32, 4,  1'b1, 4'd0, 1'b0};
    vecs[2] = '{1, 2'd2, 16, 12, 1'b1, 4'd1, 1'b0};
    vecs[3] = '{2, 2'd3, 64, 16, 1'b1, 4'd0, 1'b0};
    vecs[4] = '{1, 2'd0, 16, 0,  1'b0, 4'd0, 1'b1};
    vecs[5] = '{2, 2'd0, 64, 0,  1'b0, 4'd0, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) check($sformatf("reset d%0d outputs", d), int'(obs[d]), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      mode_v[vecs[v].dut] = vecs[v].mode;
      run_scan(vecs[v].dut, -1, -1, lat, nd);
      check($sformatf("vec%0d done latency", v), lat, vecs[v].lat);
      check($sformatf("vec%0d done pulses", v), nd, 1);
      check_results($sformatf("vec%0d", v), vecs[v].dut, vecs[v].err, vecs[v].fev,
                    vecs[v].fep, vecs[v].pass);
    end

    // Results persist while idle.
    repeat (3) @(posedge clk);
    #1;
    check_results("hold", 2, 0, 1'b0, 4'd0, 1'b1);

    // start re-pulsed during a running S=1 scan.
    mode_v[0] = 2'd0;
    run_scan(0, 5, 20, lat, nd);
    check("repulse done latency", lat, 32);
    check("repulse done pulses", nd, 1);
    check_results("repulse", 0, 0, 1'b0, 4'd0, 1'b1);

    // Async reset while pair 7 is driven, after a failing scan left results set.
    mode_v[0] = 2'd1;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("pre-reset pair", int'({obs[0].busy, obs[0].a, obs[0].b}), 16 + 7);
    check("pre-reset err_cnt", int'(obs[0].err_cnt), 2);
    #2;
    rst = 1'b1;
    #1;
    check("async reset outputs", int'(obs[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int j = 0; j < 40; j++) begin
      @(posedge clk);
      #1;
      if (obs[0].done || obs[0].busy) nd++;
    end
    check("post-reset idle activity", nd, 0);
    mode_v[0] = 2'd0;
    run_scan(0, -1, -1, lat, nd);
    check("post-reset done latency", lat, 32);
    check("post-reset done pulses", nd, 1);
    check_results("post-reset", 0, 0, 1'b0, 4'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
